// File: rtl/huff_pkg.sv
// Shared constants, types and helpers for the Huffman receive path.
package huff_pkg;
  localparam int MAX_CHAR_COUNT = 3;
  localparam int CODE_W         = 3;
  localparam int CNT_W          = 16;
  localparam int LEN_W          = $clog2(CODE_W + 1);
  localparam int IDX_W          = (MAX_CHAR_COUNT > 1) ? $clog2(MAX_CHAR_COUNT) : 1;

  typedef enum logic [1:0] {EMPTY, RUN, EMIT, ERR} dec_state_t;

  typedef struct packed {
    logic [7:0]        chr;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] mask;
  } code_entry_t;

  // Code length is carried implicitly as the number of ones in the mask.
  function automatic logic [LEN_W-1:0] popcnt(input logic [CODE_W-1:0] m);
    popcnt = '0;
    for (int i = 0; i < CODE_W; i++) popcnt = popcnt + LEN_W'(m[i]);
  endfunction
endpackage

// File: rtl/huff_code_match.sv
// Combinational table lookup: finds the entry whose codeword equals the bits seen so far.
module huff_code_match
  import huff_pkg::*;
(
  input  logic [CODE_W-1:0]                  acc_n,
  input  logic [LEN_W-1:0]                   len_n,
  input  code_entry_t [MAX_CHAR_COUNT-1:0]   tbl,
  output logic                               hit,
  output logic [IDX_W-1:0]                   hit_idx
);
  logic [MAX_CHAR_COUNT-1:0] ent_hit;

  for (genvar g = 0; g < MAX_CHAR_COUNT; g++) begin : g_ent
    assign ent_hit[g] = (tbl[g].mask != '0) &&
                        (len_n == popcnt(tbl[g].mask)) &&
                        (acc_n == (tbl[g].code & tbl[g].mask));
  end

  // Scan downwards so the lowest matching index ends up in hit_idx.
  always_comb begin
    hit     = |ent_hit;
    hit_idx = '0;
    for (int i = MAX_CHAR_COUNT - 1; i >= 0; i--)
      if (ent_hit[i]) hit_idx = IDX_W'(i);
  end
endmodule

// File: rtl/huff_decoder.sv
// Serial MSB-first Huffman decoder: loads a code table, shifts in bits one per handshake,
// emits one character per matched codeword and flags illegal codewords stickily.
module huff_decoder
  import huff_pkg::*;
#(
  parameter int SYM_CNT_W = CNT_W
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   tbl_load,
  input  logic [MAX_CHAR_COUNT-1:0][7:0]         tbl_char,
  input  logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0]  tbl_code,
  input  logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0]  tbl_mask,
  input  logic                                   bit_valid,
  input  logic                                   bit_in,
  output logic                                   bit_ready,
  output logic                                   sym_valid,
  output logic [7:0]                             sym_char,
  input  logic                                   sym_ready,
  output logic                                   err,
  output logic [SYM_CNT_W-1:0]                   sym_count
);
  dec_state_t                       state_q, state_d;
  logic [CODE_W-1:0]                acc_q, acc_d, acc_n;
  logic [LEN_W-1:0]                 len_q, len_d, len_n;
  code_entry_t [MAX_CHAR_COUNT-1:0] tbl_q, tbl_d;
  logic [7:0]                       char_q, char_d;
  logic [SYM_CNT_W-1:0]             cnt_q, cnt_d;
  logic                             hit;
  logic [IDX_W-1:0]                 hit_idx;

  assign acc_n = {acc_q[CODE_W-2:0], bit_in};
  assign len_n = len_q + 1'b1;

  huff_code_match u_match (
    .acc_n   (acc_n),
    .len_n   (len_n),
    .tbl     (tbl_q),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    len_d   = len_q;
    tbl_d   = tbl_q;
    char_d  = char_q;
    cnt_d   = cnt_q;
    if (tbl_load) begin
      // A load always wins and drops any partial codeword or pending symbol.
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
        tbl_d[i].chr  = tbl_char[i];
        tbl_d[i].code = tbl_code[i];
        tbl_d[i].mask = tbl_mask[i];
      end
      acc_d   = '0;
      len_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: if (bit_valid) begin
          if (hit) begin
            char_d  = tbl_q[hit_idx].chr;
            acc_d   = '0;
            len_d   = '0;
            state_d = EMIT;
          end else if (len_n == LEN_W'(CODE_W)) begin
            acc_d   = '0;
            len_d   = '0;
            state_d = ERR;
          end else begin
            acc_d = acc_n;
            len_d = len_n;
          end
        end
        EMIT: if (sym_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      len_q   <= '0;
      tbl_q   <= '0;
      char_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      tbl_q   <= tbl_d;
      char_q  <= char_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and error flags are pure decodes of the registered state.
  assign bit_ready = (state_q == RUN);
  assign sym_valid = (state_q == EMIT);
  assign err       = (state_q == ERR);
  assign sym_char  = char_q;
  assign sym_count = cnt_q;
endmodule

// File: tb/tb_huff_decoder.sv
// Self-checking bench for huff_decoder: cycle vectors, directed corner sequences and a
// randomized encode/decode run against a symbol-level reference model.
module tb_huff_decoder;
  import huff_pkg::*;

  // Narrow counter so the wrap case fits in a short run.
  localparam int TCW = 8;

  logic                                  clk = 1'b0;
  logic                                  reset, tbl_load, bit_valid, bit_in, sym_ready;
  logic                                  bit_ready, sym_valid, err;
  logic [MAX_CHAR_COUNT-1:0][7:0]        tbl_char;
  logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0] tbl_code, tbl_mask;
  logic [7:0]                            sym_char;
  logic [TCW-1:0]                        sym_count;

  huff_decoder #(.SYM_CNT_W(TCW)) dut (
    .clk(clk), .reset(reset), .tbl_load(tbl_load),
    .tbl_char(tbl_char), .tbl_code(tbl_code), .tbl_mask(tbl_mask),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_char(sym_char), .sym_ready(sym_ready),
    .err(err), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  typedef logic [MAX_CHAR_COUNT-1:0][7:0]        chars_t;
  typedef logic [MAX_CHAR_COUNT-1:0][CODE_W-1:0] codes_t;

  typedef struct {
    logic bv, bi, sr;
    logic ex_rdy, ex_vld;
    logic [7:0] ex_chr;
    logic ex_err;
    int   ex_cnt;
  } vec_t;

  vec_t vt[8];

  chars_t t1_c, t3_c, t4_c, sb_c;
  codes_t t1_k, t1_m, t3_m, t4_k, t4_m, sb_k, sb_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_outs(input string nm, input logic rdy, input logic vld,
                          input logic [7:0] chr, input logic er, input int cnt);
    chk({nm, ".bit_ready"}, 32'(bit_ready), 32'(rdy));
    chk({nm, ".sym_valid"}, 32'(sym_valid), 32'(vld));
    if (vld) chk({nm, ".sym_char"}, 32'(sym_char), 32'(chr));
    chk({nm, ".err"}, 32'(err), 32'(er));
    chk({nm, ".sym_count"}, 32'(sym_count), 32'(cnt % (1 << TCW)));
  endtask

  // Present inputs for one clock edge, then land on the following falling edge.
  task automatic drive(input logic bv, input logic bi, input logic sr);
    bit_valid = bv; bit_in = bi; sym_ready = sr;
    @(negedge clk);
  endtask

  task automatic load_tbl(input chars_t c, input codes_t k, input codes_t m);
    tbl_char = c; tbl_code = k; tbl_mask = m; tbl_load = 1'b1;
    bit_valid = 1'b0; sym_ready = 1'b0;
    @(negedge clk);
    tbl_load = 1'b0;
  endtask

  // Reference: pick random table symbols, encode MSB-first, expect them back in order.
  task automatic run_rand(input string nm, input chars_t c, input codes_t k, input codes_t m,
                          input int nsym);
    logic   bits[$];
    logic [7:0] expq[$];
    logic [7:0] got[$];
    int     cyc, e, len;
    logic   bv, sr, hold;
    logic [7:0] hold_chr;
    load_tbl(c, k, m);
    for (int s = 0; s < nsym; s++) begin
      do e = $urandom_range(0, MAX_CHAR_COUNT - 1); while (m[e] == '0);
      len = $countones(m[e]);
      for (int j = len - 1; j >= 0; j--) bits.push_back(k[e][j]);
      expq.push_back(c[e]);
    end
    cyc = 0; hold = 1'b0; hold_chr = '0;
    while (got.size() < nsym && cyc < 20000) begin
      if (hold) begin
        chk({nm, ".hold_valid"}, 32'(sym_valid), 32'd1);
        chk({nm, ".hold_char"}, 32'(sym_char), 32'(hold_chr));
      end
      bv = (bits.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      sr = 1'($urandom_range(0, 1));
      bit_valid = bv; bit_in = (bits.size() > 0) ? bits[0] : 1'b0; sym_ready = sr;
      if (bv && bit_ready) void'(bits.pop_front());
      if (sym_valid && sr) got.push_back(sym_char);
      hold = sym_valid && !sr;
      hold_chr = sym_char;
      @(negedge clk);
      cyc++;
    end
    bit_valid = 1'b0; sym_ready = 1'b0;
    chk({nm, ".nsym"}, 32'(got.size()), 32'(nsym));
    for (int i = 0; i < nsym && i < got.size(); i++)
      chk($sformatf("%s.sym%0d", nm, i), 32'(got[i]), 32'(expq[i]));
    chk({nm, ".err"}, 32'(err), 32'd0);
    chk({nm, ".count"}, 32'(sym_count), 32'(nsym % (1 << TCW)));
  endtask

  initial begin
    t1_c = {8'h62, 8'h61, 8'h63};            // entries: 'c', 'a', 'b'
    t1_k = {3'b011, 3'b010, 3'b000};
    t1_m = {3'b011, 3'b011, 3'b001};
    t3_c = t1_c; t3_m = {3'b011, 3'b011, 3'b000};
    t4_c = {8'h72, 8'h71, 8'h70};            // 'p'=11, 'q'=0, 'r'=10
    t4_k = {3'b010, 3'b000, 3'b011};
    t4_m = {3'b011, 3'b001, 3'b011};
    sb_c = {8'h00, 8'h31, 8'h30};            // '0'=0, '1'=1, third unused
    sb_k = {3'b000, 3'b001, 3'b000};
    sb_m = {3'b000, 3'b001, 3'b001};

    //        bv    bi    sr    rdy   vld   chr    err   cnt
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h61, 1'b0, 0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h63, 1'b0, 1};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2};
    vt[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h62, 1'b0, 2};
    vt[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3};

    reset = 1'b1; tbl_load = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
    tbl_char = '0; tbl_code = '0; tbl_mask = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_outs("reset", 1'b0, 1'b0, 8'h00, 1'b0, 0);
    chk("reset.sym_char", 32'(sym_char), 32'd0);
    drive(1'b1, 1'b1, 1'b1);
    chk_outs("empty_ignores", 1'b0, 1'b0, 8'h00, 1'b0, 0);

    // T1: bits 1,0,0,1,1 -> a, c, b
    load_tbl(t1_c, t1_k, t1_m);
    chk_outs("t1.load", 1'b1, 1'b0, 8'h00, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].bv, vt[i].bi, vt[i].sr);
      chk_outs($sformatf("t1.v%0d", i), vt[i].ex_rdy, vt[i].ex_vld, vt[i].ex_chr,
               vt[i].ex_err, vt[i].ex_cnt);
    end

    // T2: back-pressure on 'a' for 5 cycles
    load_tbl(t1_c, t1_k, t1_m);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk_outs("t2.a", 1'b0, 1'b1, 8'h61, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk_outs($sformatf("t2.hold%0d", i), 1'b0, 1'b1, 8'h61, 1'b0, 0);
    end
    drive(1'b1, 1'b0, 1'b1);
    chk_outs("t2.bubble", 1'b1, 1'b0, 8'h00, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b0);
    chk_outs("t2.c", 1'b0, 1'b1, 8'h63, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b1);
    chk_outs("t2.done", 1'b1, 1'b0, 8'h00, 1'b0, 2);

    // T3: unused entry makes 000 illegal
    load_tbl(t3_c, t1_k, t3_m);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk_outs("t3.two", 1'b1, 1'b0, 8'h00, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0);
    chk_outs("t3.err", 1'b0, 1'b0, 8'h00, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      chk_outs($sformatf("t3.sticky%0d", i), 1'b0, 1'b0, 8'h00, 1'b1, 0);
    end
    load_tbl(t1_c, t1_k, t1_m);
    chk_outs("t3.reload", 1'b1, 1'b0, 8'h00, 1'b0, 0);

    // T4: reload mid-codeword discards the partial bit and the count
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk_outs("t4.c", 1'b1, 1'b0, 8'h00, 1'b0, 1);
    drive(1'b1, 1'b1, 1'b0);
    load_tbl(t4_c, t4_k, t4_m);
    chk_outs("t4.load", 1'b1, 1'b0, 8'h00, 1'b0, 0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk_outs("t4.p", 1'b0, 1'b1, 8'h70, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b1);
    chk_outs("t4.done", 1'b1, 1'b0, 8'h00, 1'b0, 1);

    // T5: reset while a symbol is pending
    drive(1'b1, 1'b0, 1'b0);
    chk_outs("t5.q", 1'b0, 1'b1, 8'h71, 1'b0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_outs("t5.reset", 1'b0, 1'b0, 8'h00, 1'b0, 0);
    chk("t5.sym_char", 32'(sym_char), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1);
      chk_outs($sformatf("t5.idle%0d", i), 1'b0, 1'b0, 8'h00, 1'b0, 0);
    end

    // T6: randomized streams, then a counter wrap with single-bit codes
    run_rand("rand_t1", t1_c, t1_k, t1_m, 60);
    run_rand("wrap", sb_c, sb_k, sb_m, (1 << TCW) + 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
